// File: rtl/video_timing_gen.sv
// Raster timing generator: position counters, registered sync/de decode, line/frame strobes,
// frame counter and a look-ahead fetch position for the pixel source.
module video_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned HSYNC_POL = 0,
    parameter int unsigned VSYNC_POL = 0,
    parameter int unsigned PREFETCH  = 0,
    parameter int unsigned FRAME_W   = 8,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned X_W      = $clog2(H_TOTAL),
    localparam int unsigned Y_W      = $clog2(V_TOTAL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_count,
    output logic [X_W-1:0]     fetch_x,
    output logic [Y_W-1:0]     fetch_y,
    output logic               fetch_valid
);

    localparam logic [X_W-1:0] HLast    = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] VLast    = Y_W'(V_TOTAL - 1);
    localparam logic [X_W-1:0] HActive  = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] VActive  = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] HsStart  = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0] HsEnd    = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0] VsStart  = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0] VsEnd    = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [X_W-1:0] FetchLead = X_W'(PREFETCH);
    localparam logic           HPol     = 1'(HSYNC_POL);
    localparam logic           VPol     = 1'(VSYNC_POL);

    logic               run_q, run_d;
    logic [X_W-1:0]     x_q, x_d, fx_q, fx_d;
    logic [Y_W-1:0]     y_q, y_d, fy_q, fy_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic               de_q, de_d, fv_q, fv_d;
    logic               ls_q, ls_d, fs_q, fs_d;
    logic [FRAME_W-1:0] fc_q, fc_d;

    always_comb begin
        run_d   = run_q;
        x_d     = x_q;
        y_d     = y_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        de_d    = de_q;
        fv_d    = fv_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        fc_d    = fc_q;
        if (ena) begin
            run_d = 1'b1;
            // First enabled step after reset presents (0,0) instead of advancing.
            if (!run_q) begin
                x_d  = '0;
                y_d  = '0;
                fx_d = FetchLead;
                fy_d = '0;
            end else begin
                if (x_q == HLast) begin
                    x_d = '0;
                    y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
                end else begin
                    x_d = x_q + 1'b1;
                end
                if (fx_q == HLast) begin
                    fx_d = '0;
                    fy_d = (fy_q == VLast) ? '0 : fy_q + 1'b1;
                end else begin
                    fx_d = fx_q + 1'b1;
                end
            end
            de_d    = (x_d < HActive) && (y_d < VActive);
            fv_d    = (fx_d < HActive) && (fy_d < VActive);
            hsync_d = ((x_d >= HsStart) && (x_d < HsEnd)) ? HPol : ~HPol;
            vsync_d = ((y_d >= VsStart) && (y_d < VsEnd)) ? VPol : ~VPol;
            ls_d    = (x_d == '0);
            fs_d    = (x_d == '0) && (y_d == '0);
            if (run_q && fs_d) begin
                fc_d = fc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            hsync_q <= ~HPol;
            vsync_q <= ~VPol;
            de_q    <= 1'b0;
            fv_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            run_q   <= run_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            fv_q    <= fv_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
    assign fetch_x     = fx_q;
    assign fetch_y     = fy_q;
    assign fetch_valid = fv_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: default 640x480 mode, a small mode with PREFETCH=3, and a tiny active-high mode.
module tb_video_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic ena;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: defaults (800x525, PREFETCH=0)
    logic       a_hs, a_vs, a_de, a_ls, a_fs, a_fv;
    logic [9:0] a_x, a_fx, a_y, a_fy;
    logic [7:0] a_fc;

    video_timing_gen u_a (
        .clk(clk), .reset(reset), .ena(ena), .hsync(a_hs), .vsync(a_vs), .de(a_de),
        .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc),
        .fetch_x(a_fx), .fetch_y(a_fy), .fetch_valid(a_fv)
    );

    // Instance B: H 16/2/3/3 (24), V 10/2/2/2 (16), PREFETCH=3
    logic       b_hs, b_vs, b_de, b_ls, b_fs, b_fv;
    logic [4:0] b_x, b_fx;
    logic [3:0] b_y, b_fy;
    logic [7:0] b_fc;

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2), .PREFETCH(3)
    ) u_b (
        .clk(clk), .reset(reset), .ena(ena), .hsync(b_hs), .vsync(b_vs), .de(b_de),
        .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc),
        .fetch_x(b_fx), .fetch_y(b_fy), .fetch_valid(b_fv)
    );

    // Instance C: tiny mode H 4/1/1/1 (7), V 2/1/1/1 (5), active-high syncs, FRAME_W=2
    logic       c_hs, c_vs, c_de, c_ls, c_fs, c_fv;
    logic [2:0] c_x, c_fx, c_y, c_fy;
    logic [1:0] c_fc;

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1), .FRAME_W(2)
    ) u_c (
        .clk(clk), .reset(reset), .ena(ena), .hsync(c_hs), .vsync(c_vs), .de(c_de),
        .x(c_x), .y(c_y), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc),
        .fetch_x(c_fx), .fetch_y(c_fy), .fetch_valid(c_fv)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        ena   = 1'b0;
        reset = 1'b1;
        #7;
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({a_x, a_y, a_fx, a_fy, a_fc} !== 48'd0) begin
            errors++;
            $display("FAIL reset_a_pos got %h exp 0", {a_x, a_y, a_fx, a_fy, a_fc});
        end
        checks++;
        if ({a_de, a_ls, a_fs, a_fv, a_hs, a_vs} !== 6'b000011) begin
            errors++;
            $display("FAIL reset_a_flags got %b exp 000011", {a_de, a_ls, a_fs, a_fv, a_hs, a_vs});
        end
        checks++;
        if ({c_de, c_ls, c_fs, c_fv, c_hs, c_vs, c_fc} !== 8'd0) begin
            errors++;
            $display("FAIL reset_c_flags got %b exp 00000000",
                     {c_de, c_ls, c_fs, c_fv, c_hs, c_vs, c_fc});
        end
        checks++;
        if ({b_fx, b_fy} !== 9'd0) begin
            errors++;
            $display("FAIL reset_b_fetch got %h exp 0", {b_fx, b_fy});
        end
    endtask

    task automatic test_first_edge;
        ena = 1'b1;
        tick();
        checks++;
        if ({a_x, a_y, a_fc, a_de, a_ls, a_fs, a_fv, a_hs, a_vs} !== {28'd0, 6'b111111}) begin
            errors++;
            $display("FAIL first_a got %h exp %h",
                     {a_x, a_y, a_fc, a_de, a_ls, a_fs, a_fv, a_hs, a_vs}, {28'd0, 6'b111111});
        end
        checks++;
        if ({b_fx, b_fy, b_fv} !== {5'd3, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL first_b_fetch got %h exp %h", {b_fx, b_fy, b_fv}, {5'd3, 4'd0, 1'b1});
        end
        checks++;
        if ({c_de, c_ls, c_fs, c_hs, c_vs} !== 5'b11100) begin
            errors++;
            $display("FAIL first_c got %b exp 11100", {c_de, c_ls, c_fs, c_hs, c_vs});
        end
    endtask

    // Continues from the first edge: three full lines of the default mode.
    task automatic test_line_timing;
        logic [52:0] got, want;
        int x, y;
        for (int c = 1; c <= 2400; c++) begin
            if (c > 1) tick();
            x = (c - 1) % 800;
            y = (c - 1) / 800;
            want = {10'(x), 10'(y), x < 640, !(x >= 656 && x < 752), 1'b1, x == 0,
                    c == 1, 10'(x), 10'(y), x < 640, 8'd0};
            got  = {a_x, a_y, a_de, a_hs, a_vs, a_ls, a_fs, a_fx, a_fy, a_fv, a_fc};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL a_line cycle %0d got %h exp %h", c, got, want);
            end
        end
    endtask

    task automatic test_prefetch_frame;
        logic [31:0] got, want;
        int p, x, y, f, fx, fy;
        apply_reset();
        ena = 1'b1;
        for (int c = 1; c <= 769; c++) begin
            tick();
            p  = (c - 1) % 384;
            x  = p % 24;
            y  = p / 24;
            f  = (p + 3) % 384;
            fx = f % 24;
            fy = f / 24;
            want = {5'(x), 4'(y), x < 16 && y < 10, !(x >= 18 && x < 21),
                    !(y == 12 || y == 13), x == 0, p == 0, 5'(fx), 4'(fy),
                    fx < 16 && fy < 10, 8'((c - 1) / 384)};
            got  = {b_x, b_y, b_de, b_hs, b_vs, b_ls, b_fs, b_fx, b_fy, b_fv, b_fc};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL b_frame cycle %0d got %h exp %h", c, got, want);
            end
            if (x == 21) begin
                checks++;
                if ({b_fx, b_fv} !== {5'd0, y < 9 || y == 15}) begin
                    errors++;
                    $display("FAIL b_fetch_lead cycle %0d got %h exp %h", c, {b_fx, b_fv},
                             {5'd0, y < 9 || y == 15});
                end
            end
        end
    endtask

    task automatic test_tiny_frames;
        logic [18:0] got, want;
        int seq [5] = '{0, 1, 2, 3, 0};
        int p, x, y;
        apply_reset();
        ena = 1'b1;
        for (int c = 1; c <= 175; c++) begin
            tick();
            p = (c - 1) % 35;
            x = p % 7;
            y = p / 7;
            want = {3'(x), 3'(y), x < 4 && y < 2, x == 5, y == 3, x == 0, p == 0,
                    2'(((c - 1) / 35) % 4), 3'(x), 3'(y), x < 4 && y < 2};
            got  = {c_x, c_y, c_de, c_hs, c_vs, c_ls, c_fs, c_fc, c_fx, c_fy, c_fv};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL c_decode cycle %0d got %h exp %h", c, got, want);
            end
            if (p == 0) begin
                checks++;
                if (int'(c_fc) !== seq[(c - 1) / 35]) begin
                    errors++;
                    $display("FAIL c_frame_count frame %0d got %0d exp %0d", (c - 1) / 35,
                             c_fc, seq[(c - 1) / 35]);
                end
            end
        end
    endtask

    task automatic test_random_ena;
        logic [18:0] got, want;
        logic started, e;
        int ex, ey, efc;
        apply_reset();
        started = 1'b0;
        ex = 0;
        ey = 0;
        efc = 0;
        for (int i = 0; i < 400; i++) begin
            e   = 1'($urandom_range(0, 1));
            ena = e;
            tick();
            if (e) begin
                if (!started) begin
                    started = 1'b1;
                    ex = 0;
                    ey = 0;
                end else begin
                    ex = ex + 1;
                    if (ex == 7) begin
                        ex = 0;
                        ey = (ey + 1) % 5;
                        if (ey == 0) efc = (efc + 1) % 4;
                    end
                end
            end
            want = {3'(ex), 3'(ey), started && ex < 4 && ey < 2, started && ex == 5,
                    started && ey == 3, e && ex == 0, e && ex == 0 && ey == 0, 2'(efc),
                    3'(ex), 3'(ey), started && ex < 4 && ey < 2};
            got  = {c_x, c_y, c_de, c_hs, c_vs, c_ls, c_fs, c_fc, c_fx, c_fy, c_fv};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL c_random step %0d ena %0d got %h exp %h", i, e, got, want);
            end
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        ena = 1'b1;
        for (int c = 1; c <= 384 + 128; c++) tick();
        checks++;
        if ({b_x, b_y, b_fc} !== {5'd7, 4'd5, 8'd1}) begin
            errors++;
            $display("FAIL mid_pos got %h exp %h", {b_x, b_y, b_fc}, {5'd7, 4'd5, 8'd1});
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({b_x, b_y, b_fx, b_fy, b_fc} !== 26'd0) begin
            errors++;
            $display("FAIL mid_async_pos got %h exp 0", {b_x, b_y, b_fx, b_fy, b_fc});
        end
        checks++;
        if ({b_de, b_ls, b_fs, b_fv, b_hs, b_vs} !== 6'b000011) begin
            errors++;
            $display("FAIL mid_async_flags got %b exp 000011", {b_de, b_ls, b_fs, b_fv, b_hs, b_vs});
        end
        #2;
        reset = 1'b0;
        ena   = 1'b1;
        tick();
        checks++;
        if ({b_x, b_y, b_fs, b_ls, b_de, b_fc, b_fx} !== {9'd0, 3'b111, 8'd0, 5'd3}) begin
            errors++;
            $display("FAIL mid_restart got %h exp %h", {b_x, b_y, b_fs, b_ls, b_de, b_fc, b_fx},
                     {9'd0, 3'b111, 8'd0, 5'd3});
        end
    endtask

    initial begin
        reset = 1'b1;
        ena   = 1'b0;
        test_reset();
        test_first_edge();
        test_line_timing();
        test_prefetch_frame();
        test_tiny_frames();
        test_random_ena();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the HDMI display pipeline. It runs in the pixel clock domain and drives hsync, vsync and display-enable into the TMDS encoders. It also gives the pattern/pixel source the raster position, frame/line strobes, a free-running frame counter and a look-ahead fetch position, so pixel data fetched from external memory arrives in time. It generalises a fixed 640x480 timing into any mode, with selectable sync polarity and prefetch lead.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, 1 = active-high hsync, 0 = active-low
- VSYNC_POL, 0, 1 = active-high vsync, 0 = active-low
- PREFETCH, 0, fetch lead in pixel clocks; legal range 0..H_TOTAL-1
- FRAME_W, 8, frame counter width

Derived values:
- H_TOTAL = sum of the four H terms.
- V_TOTAL = sum of the four V terms.
- X_W = $clog2(H_TOTAL), Y_W = $clog2(V_TOTAL).

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- ena  in  1  advance enable; when 0 all state and outputs hold
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- de  out  1  display enable (active region)
- x  out  X_W  current horizontal position, 0..H_TOTAL-1
- y  out  Y_W  current line, 0..V_TOTAL-1
- line_start  out  1  one-cycle strobe on entering x=0
- frame_start  out  1  one-cycle strobe on entering (0,0)
- frame_count  out  FRAME_W  completed-frame counter
- fetch_x  out  X_W  position PREFETCH enabled cycles ahead of x
- fetch_y  out  Y_W  line of the fetch position
- fetch_valid  out  1  fetch position lies in the active region

## Operation
- Horizontal order per line: active, front porch, sync, back porch.
- Vertical order per frame: active, front porch, sync, back porch.
- Position advance on each enabled step: x increments; at H_TOTAL-1, x wraps to 0 and y increments; at (H_TOTAL-1, V_TOTAL-1), the position wraps to (0,0).
- de = (x < H_ACTIVE) && (y < V_ACTIVE).
- hsync is active for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
- vsync is active for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC. vsync changes only together with a line change, i.e. on entering x=0.
- Inactive sync level = ~POL.
- line_start is 1 only on the enabled cycle that enters x=0. frame_start is 1 only on the enabled cycle that enters (0,0). Both are 0 on held (ena=0) cycles.
- frame_count:
  - 0 during the first frame after reset.
  - Increments on every later entry to (0,0).
  - Wraps modulo 2^FRAME_W.
- Fetch position is an independent counter pair held exactly PREFETCH positions ahead of (x,y), with the same wrap rules. fetch_valid is the de decode of the fetch position.
- With PREFETCH=0, the fetch outputs equal x, y and de.
- The first PREFETCH positions of the first frame after reset are never presented as fetch positions. This is accepted behaviour.

## Timing
- All outputs are registered. No combinational path from ena to any output.
- Reset values:
  - de, line_start, frame_start, fetch_valid = 0
  - x, y, fetch_x, fetch_y, frame_count = 0
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL
- First enabled edge after reset deasserts: outputs present position (0,0) with de=1, line_start=1, frame_start=1, frame_count=0. The fetch outputs present position PREFETCH (wrapped).
- Each following enabled edge: one position step.
- ena=0 edge: x, y, fetch position, sync levels, de, fetch_valid and frame_count hold; strobes go to 0.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronously). The next frame restarts at (0,0) with frame_count=0.
- Line period = H_TOTAL enabled cycles. Frame period = H_TOTAL*V_TOTAL enabled cycles.

## Test plan
- Defaults, reset release, ena=1:
  - de high for cycles 1-640, hsync low for cycles 657-752, line_start every 800 cycles.
  - frame_start every 420000 cycles.
  - vsync low for exactly lines 490-491, switching on line_start.
- ena toggled at random:
  - x/y/de/sync hold on ena=0 cycles, no strobes on held cycles.
  - Totals per line and per frame are unchanged when counted in enabled cycles.
- PREFETCH=3, defaults otherwise:
  - fetch_valid rises 3 enabled cycles before de.
  - fetch_x=0 exactly when x=H_TOTAL-3 on every line.
  - Fetch wraps to line 0 three cycles before frame_start.
- Tiny mode (H 4/1/1/1, V 2/1/1/1, HSYNC_POL=1, VSYNC_POL=1, FRAME_W=2):
  - Every (x,y) is checked against the decode rules over 5 frames.
  - frame_count sequence is 0,1,2,3,0.
- Reset asserted at y=200, x=300:
  - Outputs return to reset values without waiting for a clock edge.
  - After release, the first enabled edge gives (0,0), frame_start=1, frame_count=0.
- PREFETCH=0: fetch_x/fetch_y/fetch_valid equal x/y/de on every cycle of a full frame.
